video_timing_gen: RTL
=====================

# video_timing_gen

Raster timing generator for the System86 video board: it produces the pixel-rate sync, blanking and beam-position signals that TILEGEN and the sprite/priority logic consume, replacing the hand-driven CLK_2H/HSYNC/VSYNC stimulus. It runs on the 6.144 MHz pixel clock and derives everything from one horizontal and one vertical counter, so every downstream block sees a consistent beam position. It also issues per-line and per-frame strobes used to sample scroll latches (LATCH0/LATCH1 timing) and to start CPU VBLANK interrupts.

## Interface
Parameters:
- H_TOTAL, 384, pixel clocks per line
- H_ACTIVE, 288, visible pixels (H 0..H_ACTIVE-1)
- H_SYNC_START, 304, first H with HSYNC asserted
- H_SYNC_WIDTH, 32, HSYNC length in clocks
- V_TOTAL, 264, lines per frame
- V_ACTIVE, 224, visible lines (V 0..V_ACTIVE-1)
- V_SYNC_START, 240, first line with VSYNC asserted
- V_SYNC_WIDTH, 8, VSYNC length in lines

Ports (one clock; reset is synchronous and active-high):
- CLK_6M  in  1  pixel clock, all logic on rising edge
- RST  in  1  synchronous active-high reset
- ENABLE  in  1  1 = advance counters; 0 = freeze all state and outputs
- H  out  9  horizontal position
- V  out  9  vertical position
- CLK_2H  out  1  equal to H[1]; 1.536 MHz tile phase
- HSYNC  out  1  active-high horizontal sync
- VSYNC  out  1  active-high vertical sync
- HBLANK  out  1  1 when H >= H_ACTIVE
- VBLANK  out  1  1 when V >= V_ACTIVE
- LINE_START  out  1  one-clock pulse, H == 0
- FRAME_START  out  1  one-clock pulse, H == 0 and V == 0

## Operation
- H counts 0..H_TOTAL-1, wraps to 0. V increments only on the clock where H wraps. V counts 0..V_TOTAL-1 and wraps to 0 when H and V both wrap.
- All outputs are registered. The decode is computed from the next-state counter values, so every output is coherent with the H/V values in the same cycle. There is no skew between H and HSYNC.
- HSYNC = (H >= H_SYNC_START) and (H < H_SYNC_START+H_SYNC_WIDTH).
- VSYNC = (V >= V_SYNC_START) and (V < V_SYNC_START+V_SYNC_WIDTH). VSYNC therefore changes only together with an H wrap.
- Counter widths are fixed at 9 bits. Parameters must satisfy TOTAL <= 512 and SYNC_START+SYNC_WIDTH <= TOTAL. Sync never wraps across 0.
- ENABLE = 0 holds H, V and every output (including the strobes) at their current values. A strobe that is high stays high until ENABLE returns.
- Reset values: H=0, V=0, CLK_2H=0, HSYNC=0, VSYNC=0, HBLANK=0, VBLANK=0, LINE_START=1, FRAME_START=1. These are the decoded values for position (0,0).
- RST takes priority over ENABLE. RST mid-frame puts the block at (0,0) on the next edge, and counting resumes from 0 the cycle after RST falls.

## Timing
- Latency: 0 cycles between H/V and the decoded outputs. Everything updates on the same edge.
- Line period: H_TOTAL clocks. Frame period: H_TOTAL×V_TOTAL clocks, which is 101376 clocks at the defaults (≈60.6 Hz).
- LINE_START is high for 1 clock per line and FRAME_START for 1 clock per frame, each when ENABLE = 1 throughout.
- CLK_2H has a period of 4 clocks and a 50% duty cycle. It is low for H mod 4 ∈ {0,1}.

## Structure
- Shared package `system86_video_pkg` holds:
  - the default timing constants (the eight values above);
  - the 9-bit position width.
- The natural sub-module is `mod_counter`: a parameterised wrap counter with count-enable, synchronous reset and a wrap output.
  - One instance serves H; its wrap output feeds the V instance's enable.
  - Decode logic stays in the top module.

## Test plan
- Reset release: hold RST for 3 clocks, then release. Expect H=0, V=0, FRAME_START=1 and LINE_START=1 on the first cycle, H=1 and both strobes 0 on the next, and H=2, CLK_2H=1 at the second clock after release.
- Horizontal decode:
  - HBLANK rises exactly at H=288.
  - HSYNC is high for H=304..335 (32 clocks).
  - H wraps 383→0 with LINE_START=1 and V incremented on the same edge.
- Vertical decode: run one frame. Expect VBLANK to rise at V=224, VSYNC to be high for lines 240..247 (8×384 = 3072 clocks), and FRAME_START pulses exactly 101376 clocks apart.
- ENABLE freeze: deassert ENABLE at H=383, V=263 for 10 clocks. All outputs hold. On re-enable, the next edge gives H=0, V=0 and FRAME_START=1.
- Mid-frame reset: assert RST at H=150, V=100 for 1 clock. Next edge gives H=0, V=0 with all syncs and blanks 0. The following frame length is still 101376 clocks.
- Non-default parameters: H_TOTAL=16, H_ACTIVE=8, H_SYNC_START=10, H_SYNC_WIDTH=2, V_TOTAL=4, V_ACTIVE=2, V_SYNC_START=3, V_SYNC_WIDTH=1. The frame period must be 64 clocks, with HSYNC at H=10..11 and VSYNC on line 3 only.

Source files
------------

// File: rtl/system86_video_pkg.sv
// system86_video_pkg: default raster timing constants and beam-position type
package system86_video_pkg;
    localparam int POS_W            = 9;
    localparam int H_TOTAL_DEF      = 384;
    localparam int H_ACTIVE_DEF     = 288;
    localparam int H_SYNC_START_DEF = 304;
    localparam int H_SYNC_WIDTH_DEF = 32;
    localparam int V_TOTAL_DEF      = 264;
    localparam int V_ACTIVE_DEF     = 224;
    localparam int V_SYNC_START_DEF = 240;
    localparam int V_SYNC_WIDTH_DEF = 8;
    typedef logic [POS_W-1:0] pos_t;
endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: beam position, sync, blank and strobe bundle
interface video_timing_gen_if;
    import system86_video_pkg::*;
    pos_t H;
    pos_t V;
    logic CLK_2H;
    logic HSYNC;
    logic VSYNC;
    logic HBLANK;
    logic VBLANK;
    logic LINE_START;
    logic FRAME_START;
    modport master (output H, V, CLK_2H, HSYNC, VSYNC, HBLANK, VBLANK, LINE_START, FRAME_START);
    modport slave  (input  H, V, CLK_2H, HSYNC, VSYNC, HBLANK, VBLANK, LINE_START, FRAME_START);
endinterface

// File: rtl/video_timing_gen_mod_counter.sv
// mod_counter: 0..TOTAL-1 wrap counter with enable, sync reset and wrap flag
module mod_counter
    import system86_video_pkg::*;
#(
    parameter int TOTAL = H_TOTAL_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output pos_t count_q,
    output pos_t count_d,
    output logic wrap
);
    // next count; wrap is only asserted on an enabled terminal count
    always_comb begin
        wrap    = en && (count_q == pos_t'(TOTAL - 1));
        count_d = wrap ? '0 : en ? count_q + pos_t'(1) : count_q;
    end
    // count register
    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: H/V raster counters with registered sync/blank/strobe decode
module video_timing_gen
    import system86_video_pkg::*;
#(
    parameter int H_TOTAL      = H_TOTAL_DEF,
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int H_SYNC_START = H_SYNC_START_DEF,
    parameter int H_SYNC_WIDTH = H_SYNC_WIDTH_DEF,
    parameter int V_TOTAL      = V_TOTAL_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int V_SYNC_START = V_SYNC_START_DEF,
    parameter int V_SYNC_WIDTH = V_SYNC_WIDTH_DEF
) (
    input  logic                CLK_6M,
    input  logic                RST,
    input  logic                ENABLE,
    video_timing_gen_if.master  vid
);
    pos_t h_q, h_d, v_q, v_d;
    logic h_wrap, v_wrap;
    logic clk2h_q, hsync_q, vsync_q, hblank_q, vblank_q, line_q, frame_q;
    logic clk2h_d, hsync_d, vsync_d, hblank_d, vblank_d, line_d, frame_d;

    mod_counter #(.TOTAL(H_TOTAL)) u_h (
        .clk(CLK_6M), .rst(RST), .en(ENABLE), .count_q(h_q), .count_d(h_d), .wrap(h_wrap)
    );
    mod_counter #(.TOTAL(V_TOTAL)) u_v (
        .clk(CLK_6M), .rst(RST), .en(h_wrap), .count_q(v_q), .count_d(v_d), .wrap(v_wrap)
    );

    // decode from next-state position so outputs line up with H/V; strobes fire on wrap and hold while frozen
    always_comb begin
        clk2h_d  = h_d[1];
        hblank_d = int'(h_d) >= H_ACTIVE;
        vblank_d = int'(v_d) >= V_ACTIVE;
        hsync_d  = int'(h_d) >= H_SYNC_START && int'(h_d) < H_SYNC_START + H_SYNC_WIDTH;
        vsync_d  = int'(v_d) >= V_SYNC_START && int'(v_d) < V_SYNC_START + V_SYNC_WIDTH;
        line_d   = h_wrap || (line_q && !ENABLE);
        frame_d  = v_wrap || (frame_q && !ENABLE);
    end

    // output registers; reset values are the decode of position (0,0)
    always_ff @(posedge CLK_6M) begin
        if (RST) begin
            clk2h_q  <= 1'b0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            line_q   <= 1'b1;
            frame_q  <= 1'b1;
        end else begin
            clk2h_q  <= clk2h_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            line_q   <= line_d;
            frame_q  <= frame_d;
        end
    end

    assign vid.H           = h_q;
    assign vid.V           = v_q;
    assign vid.CLK_2H      = clk2h_q;
    assign vid.HSYNC       = hsync_q;
    assign vid.VSYNC       = vsync_q;
    assign vid.HBLANK      = hblank_q;
    assign vid.VBLANK      = vblank_q;
    assign vid.LINE_START  = line_q;
    assign vid.FRAME_START = frame_q;
endmodule
